// File: rtl/wb_mem_responder_pkg.sv
// Shared types and constants for the Wishbone memory responder.
// FSM encoding, byte-offset helper and statistics counter width.
package wb_mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int STATS_W = 32;

    // Number of ADR bits that select a byte inside one data word.
    function automatic int off_bits(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/wb_mem_responder_ram.sv
// Single-port synchronous RAM with per-byte write enables and registered read.
// Contents are intentionally not reset.
module wb_mem_responder_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024
) (
    input  logic                      clk_i,
    input  logic                      we,
    input  logic [DATA_WIDTH/8-1:0]   be,
    input  logic [$clog2(DEPTH)-1:0]  addr,
    input  logic [DATA_WIDTH-1:0]     wdata,
    output logic [DATA_WIDTH-1:0]     rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DATA_WIDTH / 8; i++) begin
            if (we && be[i]) begin
                mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/wb_mem_responder.sv
// Wishbone classic responder backed by word-addressed RAM, with programmable wait states.
// Optional statistics counters are built when WB_MEM_RESPONDER_STATS_EN is defined.
module wb_mem_responder
    import wb_mem_responder_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    MEM_DEPTH   = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [ADDR_WIDTH-1:0]     ADR,
    input  logic [DATA_WIDTH-1:0]     DAT_W,
    output logic [DATA_WIDTH-1:0]     DAT_R,
    input  logic                      CYC,
    input  logic                      STB,
    input  logic                      WE,
    input  logic [DATA_WIDTH/8-1:0]   SEL,
    output logic                      ACK,
    output logic [1:0]                dbg_state,
    output logic                      ERR
`ifdef WB_MEM_RESPONDER_STATS_EN
    ,
    input  logic                      stats_clr,
    output logic [STATS_W-1:0]        rd_count,
    output logic [STATS_W-1:0]        wr_count,
    output logic [STATS_W-1:0]        err_count
`endif
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF_W = off_bits(DATA_WIDTH);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] LO_ADDR = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0] HI_ADDR = LO_ADDR + (ADDR_WIDTH + 1)'(MEM_DEPTH * BYTES);

    // Handshake: a request is CYC&STB sampled in IDLE; it must stay asserted
    // through WAIT, and is answered by a one-cycle ACK or ERR in RESP.
    state_t                state;
    logic [3:0]            wait_cnt;
    logic                  ack_q;
    logic                  err_q;
    logic                  we_q;
    logic [BYTES-1:0]      sel_q;
    logic [DATA_WIDTH-1:0] wdat_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  dec_err_q;

    logic [ADDR_WIDTH:0]   adr_ext;
    logic [ADDR_WIDTH-1:0] adr_off;
    logic [IDX_W-1:0]      bus_idx;
    logic                  dec_err;
    logic                  req;

    assign req     = CYC && STB;
    assign adr_ext = {1'b0, ADR};
    assign adr_off = ADR - BASE_ADDR;
    assign bus_idx = adr_off[OFF_W +: IDX_W];
    assign dec_err = (adr_ext < LO_ADDR) || (adr_ext >= HI_ADDR) ||
                     (ADR[OFF_W-1:0] != '0) || (SEL == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            wait_cnt <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ack_q <= 1'b0;
                    err_q <= 1'b0;
                    if (req) begin
                        we_q      <= WE;
                        sel_q     <= SEL;
                        wdat_q    <= DAT_W;
                        idx_q     <= bus_idx;
                        dec_err_q <= dec_err;
                        if (WAIT_STATES == 0) begin
                            state <= RESP;
                            ack_q <= !dec_err;
                            err_q <= dec_err;
                        end else begin
                            wait_cnt <= 4'(WAIT_STATES - 1);
                            state    <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!req) begin
                        state <= IDLE;
                    end else if (wait_cnt == '0) begin
                        state <= RESP;
                        ack_q <= !dec_err_q;
                        err_q <= dec_err_q;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    ack_q <= 1'b0;
                    err_q <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    ack_q <= 1'b0;
                    err_q <= 1'b0;
                end
            endcase
        end
    end

    // RAM reads the live bus address while idle so a zero-wait read has data in RESP.
    logic [IDX_W-1:0]      ram_addr;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_q;
    logic [DATA_WIDTH-1:0] lane_mask;

    assign ram_addr = (state == IDLE) ? bus_idx : idx_q;
    assign ram_we   = (state == RESP) && ack_q && we_q && !rst_i;

    wb_mem_responder_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MEM_DEPTH)
    ) u_ram (
        .clk_i (clk_i),
        .we    (ram_we),
        .be    (sel_q),
        .addr  (ram_addr),
        .wdata (wdat_q),
        .rdata (ram_q)
    );

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < BYTES; i++) begin
            lane_mask[i*8 +: 8] = {8{sel_q[i]}};
        end
    end

    assign DAT_R     = (ack_q && !we_q) ? (ram_q & lane_mask) : '0;
    assign ACK       = ack_q;
    assign ERR       = err_q;
    assign dbg_state = state;

`ifdef WB_MEM_RESPONDER_STATS_EN
    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // Clear has priority over a coinciding increment.
    always_ff @(posedge clk_i) begin
        if (rst_i || stats_clr) begin
            rd_count  <= '0;
            wr_count  <= '0;
            err_count <= '0;
        end else if (state == RESP) begin
            if (err_q) begin
                err_count <= sat_inc(err_count);
            end else if (we_q) begin
                wr_count <= sat_inc(wr_count);
            end else begin
                rd_count <= sat_inc(rd_count);
            end
        end
    end
`endif

endmodule
